decision_tx_framer: RTL and testbench
=====================================

// Module: decision_tx_framer
// PURPOSE
//   Sits between the Logic->TX pipeline register and the byte-wide UART TX.
//   Accepts one decision word (type, data, ingress and decision timestamps) per handshake.
//   Serialises each word into a fixed-length byte frame for the TX serialiser.
//   The frame carries an ingress-to-decision latency field and an XOR checksum.
// PARAMETERS
//   SOF_BYTE  8'hA5  start-of-frame marker, always byte 0 of every frame
//   LAT_W     16     latency field width in bits; a multiple of 8, sent MSB first
// PORTS
//   clk           in   1   clock
//   rst_n         in   1   reset, asynchronous, active-low
//   in_valid      in   1   decision word valid (from l2t_out_valid)
//   in_ready      out  1   framer can accept a word (to l2t_out_ready)
//   in_type       in   8   decision type
//   in_data       in   32  decision payload
//   in_t_ingress  in   32  ingress cycle stamp aligned to this word
//   in_t_decision in   32  decision cycle stamp aligned to this word
//   tx_byte       out  8   frame byte to the UART TX
//   tx_valid      out  1   tx_byte valid
//   tx_ready      in   1   UART TX accepts tx_byte
//   busy          out  1   frame in progress (state != IDLE)
//   frame_cnt     out  16  count of completed frames, wraps at 2^16
// BEHAVIOUR
//   Reset values: in_ready=1, tx_valid=0, tx_byte=0, busy=0, frame_cnt=0; state=IDLE, index=0.
//   States:
//     IDLE: in_ready=1. On in_valid&&in_ready, capture all in_* fields and the latency, then go to SEND with index=0.
//     SEND: in_ready=0, tx_valid=1, tx_byte=frame[index]. On tx_valid&&tx_ready, index++.
//     Leaving SEND: acceptance of the last byte -> IDLE, frame_cnt++.
//   Handshake:
//     in_ready is low for the whole of SEND. The next word is accepted the cycle after the last byte is accepted.
//     Minimum frame period is N+1 cycles, where N is the frame length.
//     tx_byte and tx_valid are registered and stay stable while tx_ready=0 (no bubbles, no change under stall).
//   Latency:
//     diff = in_t_decision - in_t_ingress, computed mod 2^32, so counter wrap is handled.
//     lat = (diff > 2^LAT_W-1) ? all-ones : diff[LAT_W-1:0]. This saturates and never truncates.
//   Frame layout:
//     SOF_BYTE, in_type, in_data[31:24], [23:16], [15:8], [7:0], latency bytes MSB first, CHK.
//     CHK = XOR of every byte after SOF and before CHK. SOF is excluded.
//     CHK accumulates in a register as bytes are accepted; it is not recomputed combinationally.
//   Boundary conditions:
//     - in_valid while busy: ignored; upstream holds it (in_ready=0).
//     - tx_ready held low indefinitely: hold the current byte; no timeout.
//     - frame_cnt 0xFFFF +1 -> 0x0000.
//     - Reset mid-frame: frame aborted, all outputs return to reset values immediately; no partial resume.
// CONFIGURATION
//   DECISION_TX_LATENCY_EN defined:
//     Latency field included; N = 7 + LAT_W/8 (9 by default).
//   DECISION_TX_LATENCY_EN undefined:
//     Latency bytes omitted; N = 7 (SOF, type, 4 data bytes, CHK).
//     CHK covers type and data only. Latency logic is not synthesised.
// TESTING
//   1. type=0x41, data=0x12345678, ingress=100, decision=130, tx_ready=1.
//      With EN: A5 41 12 34 56 78 00 1E 57. Without EN: A5 41 12 34 56 78 49. frame_cnt=1.
//   2. Same frame, tx_ready toggled 1/0 every cycle.
//      -> Identical byte sequence. tx_byte stable whenever tx_valid&&!tx_ready.
//   3. ingress=0xFFFFFFF0, decision=0x00000010 -> latency bytes 00 20 (wrap handled).
//      ingress=0, decision=0x00012345 -> latency bytes FF FF (saturated).
//   4. Two words back-to-back with in_valid held high.
//      -> Second accepted exactly 1 cycle after the last byte of the first. in_ready=0 throughout SEND. frame_cnt=2.
//   5. rst_n asserted after byte 3 of a frame.
//      -> tx_valid=0, in_ready=1, frame_cnt unchanged-to-0. The next frame after release starts with A5.
//   6. Preload 65535 frames (or force frame_cnt=0xFFFF), send one frame -> frame_cnt=0x0000.

Source files
------------

// File: rtl/decision_tx_framer.sv
// ---------------------------------------------------------------------------
// decision_tx_framer
//
// Takes one decision word per valid/ready handshake from the Logic->TX
// pipeline register and turns it into a fixed-length byte frame for the
// byte-wide UART TX serialiser:
//
//   SOF_BYTE, type, data[31:24], data[23:16], data[15:8], data[7:0],
//   [latency bytes, MSB first], CHK
//
// CHK is the XOR of every byte between SOF and CHK. SOF itself is excluded.
//
// Optional feature (compile-time macro DECISION_TX_LATENCY_EN):
//   defined   : a LAT_W-bit ingress-to-decision latency field is inserted
//               before CHK. Frame length is 7 + LAT_W/8 bytes.
//   undefined : no latency field and no latency logic. Frame length is 7.
//
// Parameters:
//   SOF_BYTE       start-of-frame marker, byte 0 of every frame
//   LAT_W          latency field width in bits (multiple of 8)
//
// Ports:
//   clk            clock
//   rst_n          asynchronous, active-low reset
//   in_valid       decision word valid
//   in_ready       framer can accept a word (high only while idle)
//   in_type        decision type
//   in_data        decision payload
//   in_t_ingress   ingress cycle stamp of this word
//   in_t_decision  decision cycle stamp of this word
//   tx_byte        current frame byte (registered)
//   tx_valid       tx_byte valid (registered)
//   tx_ready       UART TX accepts tx_byte
//   busy           a frame is in progress
//   frame_cnt      completed frames, wraps at 2^16
// ---------------------------------------------------------------------------
module decision_tx_framer #(
    parameter logic [7:0] SOF_BYTE = 8'hA5,
    parameter int         LAT_W    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_type,
    input  logic [31:0] in_data,
    input  logic [31:0] in_t_ingress,
    input  logic [31:0] in_t_decision,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic [15:0] frame_cnt
);

`ifdef DECISION_TX_LATENCY_EN
    localparam int LAT_BYTES = LAT_W / 8;
`else
    localparam int LAT_BYTES = 0;
    localparam int unused_lat_w = LAT_W;
`endif

    localparam int                FRAME_LEN = 7 + LAT_BYTES;
    localparam int                IDX_W     = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(FRAME_LEN - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [7:0]        type_q;
    logic [31:0]       data_q;
    logic [IDX_W-1:0]  idx;
    logic [7:0]        chk_q;

    logic [IDX_W-1:0]  idx_inc;
    logic [7:0]        chk_next;
    logic [7:0]        field_byte;
    logic [7:0]        next_byte;
    logic              tx_fire;
    logic              last_fire;

    assign tx_fire   = tx_valid && tx_ready;
    assign last_fire = tx_fire && (idx == LAST_IDX);

`ifdef DECISION_TX_LATENCY_EN
    // Subtraction is mod 2^32 so a wrapped ingress counter still yields the
    // true distance; anything that does not fit LAT_W bits saturates.
    localparam logic [31:0] LAT_MAX = (LAT_W >= 32) ? 32'hFFFF_FFFF
                                                    : 32'((64'd1 << LAT_W) - 64'd1);

    logic [LAT_W-1:0]  lat_q;
    logic [31:0]       lat_diff;
    logic [LAT_W-1:0]  lat_sat;

    always_comb begin
        lat_diff = in_t_decision - in_t_ingress;
        lat_sat  = (lat_diff > LAT_MAX) ? '1 : lat_diff[LAT_W-1:0];
    end
`else
    logic unused_stamps;
    assign unused_stamps = ^{in_t_ingress, in_t_decision};
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                busy = 1'b1;
                if (last_fire) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Byte that follows the one currently on tx_byte. The checksum byte is
    // the running XOR plus the byte being accepted right now, so it comes
    // straight out of the accumulator path rather than a wide XOR tree.
    always_comb begin
        idx_inc    = idx + 1'b1;
        chk_next   = (idx == '0) ? 8'h00 : (chk_q ^ tx_byte);
        field_byte = 8'h00;
        case (int'(idx_inc))
            1:       field_byte = type_q;
            2:       field_byte = data_q[31:24];
            3:       field_byte = data_q[23:16];
            4:       field_byte = data_q[15:8];
            5:       field_byte = data_q[7:0];
            default: field_byte = 8'h00;
        endcase
`ifdef DECISION_TX_LATENCY_EN
        for (int j = 0; j < LAT_BYTES; j++) begin
            if (int'(idx_inc) == 6 + j) begin
                field_byte = lat_q[LAT_W-1-8*j -: 8];
            end
        end
`endif
        next_byte = (idx_inc == LAST_IDX) ? chk_next : field_byte;
    end

    // Capture, byte sequencing, checksum accumulation and frame counting.
    // tx_byte/tx_valid only move on acceptance, so they hold under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            type_q    <= 8'h00;
            data_q    <= 32'h0;
`ifdef DECISION_TX_LATENCY_EN
            lat_q     <= '0;
`endif
            idx       <= '0;
            chk_q     <= 8'h00;
            tx_byte   <= 8'h00;
            tx_valid  <= 1'b0;
            frame_cnt <= 16'h0000;
        end else if (state == IDLE) begin
            if (in_valid) begin
                type_q   <= in_type;
                data_q   <= in_data;
`ifdef DECISION_TX_LATENCY_EN
                lat_q    <= lat_sat;
`endif
                idx      <= '0;
                chk_q    <= 8'h00;
                tx_byte  <= SOF_BYTE;
                tx_valid <= 1'b1;
            end
        end else if (tx_fire) begin
            if (idx == LAST_IDX) begin
                idx       <= '0;
                chk_q     <= 8'h00;
                tx_byte   <= 8'h00;
                tx_valid  <= 1'b0;
                frame_cnt <= frame_cnt + 16'd1;
            end else begin
                idx     <= idx_inc;
                chk_q   <= chk_next;
                tx_byte <= next_byte;
            end
        end
    end

endmodule

// File: tb/tb_decision_tx_framer.sv
// ---------------------------------------------------------------------------
// tb_decision_tx_framer
//
// Self-checking bench for decision_tx_framer. Expected frames come from a
// reference builder that assembles the byte list directly from the frame
// layout (plain arithmetic for latency, XOR over the list for CHK).
// Honours DECISION_TX_LATENCY_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_decision_tx_framer;

`ifdef DECISION_TX_LATENCY_EN
    localparam int N = 9;
`else
    localparam int N = 7;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_type;
    logic [31:0] in_data;
    logic [31:0] in_t_ingress;
    logic [31:0] in_t_decision;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic [15:0] frame_cnt;

    int          checks;
    int          errors;
    int          cyc;
    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];
    int          stall_bad;
    int          inrdy_bad;
    bit          timed_out;
    logic [15:0] exp_cnt;

    decision_tx_framer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_type       (in_type),
        .in_data       (in_data),
        .in_t_ingress  (in_t_ingress),
        .in_t_decision (in_t_decision),
        .tx_byte       (tx_byte),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .busy          (busy),
        .frame_cnt     (frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference frame: layout assembled byte by byte, latency as a plain
    // integer difference with wrap and saturation, CHK as XOR of bytes 1..end.
    function automatic void build_exp(input logic [7:0] t, input logic [31:0] d,
                                      input logic [31:0] ing, input logic [31:0] dec);
        logic [7:0] c;
`ifdef DECISION_TX_LATENCY_EN
        longint a;
        longint b;
        longint diff;
        longint lat;
`endif
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(t);
        exp_q.push_back(d[31:24]);
        exp_q.push_back(d[23:16]);
        exp_q.push_back(d[15:8]);
        exp_q.push_back(d[7:0]);
`ifdef DECISION_TX_LATENCY_EN
        a    = {32'b0, ing};
        b    = {32'b0, dec};
        diff = b - a;
        if (diff < 0) diff = diff + (longint'(1) << 32);
        lat  = (diff > 65535) ? 65535 : diff;
        exp_q.push_back(8'(lat >> 8));
        exp_q.push_back(8'(lat));
`else
        c = ing[0] ^ dec[0];
`endif
        c = 8'h00;
        for (int i = 1; i < exp_q.size(); i++) c = c ^ exp_q[i];
        exp_q.push_back(c);
    endfunction

    // Offers one word and collects accepted bytes into got_q while tracking
    // stall stability and in_ready during the frame. mode: 0 always ready,
    // 1 toggle, 2 random. abort_after > 0 stops after that many bytes.
    task automatic run_frame(input logic [7:0] t, input logic [31:0] d,
                             input logic [31:0] ing, input logic [31:0] dec,
                             input int mode, input int abort_after);
        int         guard;
        bit         prev_stalled;
        logic [7:0] prev_byte;
        bit         tog;
        got_q.delete();
        stall_bad = 0;
        inrdy_bad = 0;
        timed_out = 0;
        @(negedge clk);
        in_type       = t;
        in_data       = d;
        in_t_ingress  = ing;
        in_t_decision = dec;
        in_valid      = 1'b1;
        tx_ready      = 1'b0;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) timed_out = 1;
        @(negedge clk);
        in_valid     = 1'b0;
        prev_stalled = 0;
        prev_byte    = 8'h00;
        tog          = 1'b1;
        guard        = 0;
        while (got_q.size() < N && guard < 500 &&
               !(abort_after > 0 && got_q.size() >= abort_after)) begin
            case (mode)
                0:       tx_ready = 1'b1;
                1:       begin tx_ready = tog; tog = ~tog; end
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            if (prev_stalled && tx_byte !== prev_byte) stall_bad++;
            if (tx_valid && in_ready) inrdy_bad++;
            if (tx_valid && tx_ready) got_q.push_back(tx_byte);
            prev_stalled = tx_valid && !tx_ready;
            prev_byte    = tx_byte;
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) timed_out = 1;
        tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_valid got %b want 0", tx_valid); end
        checks++; if (tx_byte !== 8'h00) begin errors++; $display("[TB] FAIL reset_tx_byte got %h want 00", tx_byte); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        checks++; if (frame_cnt !== 16'h0) begin errors++; $display("[TB] FAIL reset_frame_cnt got %h want 0000", frame_cnt); end
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 16'h0;
    endtask

    task automatic test_basic();
        logic [7:0] lit[$];
`ifdef DECISION_TX_LATENCY_EN
        lit = '{8'hA5, 8'h41, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h1E, 8'h57};
`else
        lit = '{8'hA5, 8'h41, 8'h12, 8'h34, 8'h56, 8'h78, 8'h49};
`endif
        build_exp(8'h41, 32'h12345678, 32'd100, 32'd130);
        run_frame(8'h41, 32'h12345678, 32'd100, 32'd130, 0, 0);
        exp_cnt++;
        checks++; if (timed_out || got_q.size() != N) begin errors++; $display("[TB] FAIL basic_len got %0d want %0d", got_q.size(), N); end
        for (int i = 0; i < N && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== lit[i]) begin errors++; $display("[TB] FAIL basic_byte%0d got %h want %h", i, got_q[i], lit[i]); end
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL basic_model%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("[TB] FAIL basic_frame_cnt got %h want %h", frame_cnt, exp_cnt); end
        checks++; if (inrdy_bad != 0) begin errors++; $display("[TB] FAIL basic_in_ready_in_send got %0d want 0", inrdy_bad); end
    endtask

    task automatic test_stall();
        build_exp(8'h41, 32'h12345678, 32'd100, 32'd130);
        run_frame(8'h41, 32'h12345678, 32'd100, 32'd130, 1, 0);
        exp_cnt++;
        checks++; if (timed_out || got_q.size() != N) begin errors++; $display("[TB] FAIL stall_len got %0d want %0d", got_q.size(), N); end
        for (int i = 0; i < N && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL stall_byte%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (stall_bad != 0) begin errors++; $display("[TB] FAIL stall_hold got %0d changes want 0", stall_bad); end
        checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("[TB] FAIL stall_frame_cnt got %h want %h", frame_cnt, exp_cnt); end
    endtask

    task automatic test_latency();
        logic [31:0] ing_v[2];
        logic [31:0] dec_v[2];
        logic [15:0] lat_v[2];
        ing_v = '{32'hFFFF_FFF0, 32'h0000_0000};
        dec_v = '{32'h0000_0010, 32'h0001_2345};
        lat_v = '{16'h0020, 16'hFFFF};
        for (int k = 0; k < 2; k++) begin
            build_exp(8'h07, 32'hCAFEF00D, ing_v[k], dec_v[k]);
            run_frame(8'h07, 32'hCAFEF00D, ing_v[k], dec_v[k], 0, 0);
            exp_cnt++;
            checks++; if (timed_out || got_q.size() != N) begin errors++; $display("[TB] FAIL lat%0d_len got %0d want %0d", k, got_q.size(), N); end
            for (int i = 0; i < N && i < got_q.size(); i++) begin
                checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL lat%0d_byte%0d got %h want %h", k, i, got_q[i], exp_q[i]); end
            end
`ifdef DECISION_TX_LATENCY_EN
            if (got_q.size() == N) begin
                checks++; if ({got_q[6], got_q[7]} !== lat_v[k]) begin errors++; $display("[TB] FAIL lat%0d_field got %h want %h", k, {got_q[6], got_q[7]}, lat_v[k]); end
            end
`else
            checks++; if (got_q.size() == N && got_q[6] !== (8'h07 ^ 8'hCA ^ 8'hFE ^ 8'hF0 ^ 8'h0D)) begin errors++; $display("[TB] FAIL lat%0d_chk got %h want %h lat %h", k, got_q[6], 8'h07 ^ 8'hCA ^ 8'hFE ^ 8'hF0 ^ 8'h0D, lat_v[k]); end
`endif
        end
    endtask

    task automatic test_random();
        logic [7:0]  t;
        logic [31:0] d;
        logic [31:0] ing;
        logic [31:0] dec;
        for (int k = 0; k < 20; k++) begin
            t   = 8'($urandom);
            d   = $urandom;
            ing = $urandom;
            if (k % 3 == 0) dec = $urandom;
            else            dec = ing + $urandom_range(0, 70000);
            build_exp(t, d, ing, dec);
            run_frame(t, d, ing, dec, 2, 0);
            exp_cnt++;
            checks++; if (timed_out || got_q.size() != N) begin errors++; $display("[TB] FAIL rnd%0d_len got %0d want %0d", k, got_q.size(), N); end
            for (int i = 0; i < N && i < got_q.size(); i++) begin
                checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL rnd%0d_byte%0d got %h want %h", k, i, got_q[i], exp_q[i]); end
            end
            checks++; if (stall_bad != 0 || inrdy_bad != 0) begin errors++; $display("[TB] FAIL rnd%0d_handshake got stall %0d inrdy %0d want 0 0", k, stall_bad, inrdy_bad); end
        end
        checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("[TB] FAIL rnd_frame_cnt got %h want %h", frame_cnt, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_a[$];
        logic [7:0] exp_b[$];
        int         acc_count;
        int         accept_b_cyc;
        int         last_a_cyc;
        int         guard;
        build_exp(8'h11, 32'hA0B0C0D0, 32'd5, 32'd9);
        exp_a = exp_q;
        build_exp(8'h22, 32'h01020304, 32'd1000, 32'd3000);
        exp_b = exp_q;
        got_q.delete();
        inrdy_bad    = 0;
        acc_count    = 0;
        accept_b_cyc = -1;
        last_a_cyc   = -1;
        guard        = 0;
        @(negedge clk);
        tx_ready      = 1'b1;
        in_type       = 8'h11;
        in_data       = 32'hA0B0C0D0;
        in_t_ingress  = 32'd5;
        in_t_decision = 32'd9;
        in_valid      = 1'b1;
        while (got_q.size() < 2 * N && guard < 200) begin
            if (tx_valid && in_ready) inrdy_bad++;
            if (in_valid && in_ready) begin
                acc_count++;
                if (acc_count == 2) accept_b_cyc = cyc;
            end
            if (tx_valid && tx_ready) begin
                got_q.push_back(tx_byte);
                if (got_q.size() == N) last_a_cyc = cyc;
            end
            @(negedge clk);
            guard++;
            if (acc_count == 1) begin
                in_type       = 8'h22;
                in_data       = 32'h01020304;
                in_t_ingress  = 32'd1000;
                in_t_decision = 32'd3000;
            end else if (acc_count >= 2) begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        tx_ready = 1'b0;
        exp_cnt  = exp_cnt + 16'd2;
        checks++; if (got_q.size() != 2 * N) begin errors++; $display("[TB] FAIL b2b_len got %0d want %0d", got_q.size(), 2 * N); end
        for (int i = 0; i < N && i + N < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_a[i]) begin errors++; $display("[TB] FAIL b2b_a_byte%0d got %h want %h", i, got_q[i], exp_a[i]); end
            checks++; if (got_q[i+N] !== exp_b[i]) begin errors++; $display("[TB] FAIL b2b_b_byte%0d got %h want %h", i, got_q[i+N], exp_b[i]); end
        end
        checks++; if (accept_b_cyc != last_a_cyc + 1 || last_a_cyc < 0) begin errors++; $display("[TB] FAIL b2b_gap got accept %0d want %0d", accept_b_cyc, last_a_cyc + 1); end
        checks++; if (inrdy_bad != 0) begin errors++; $display("[TB] FAIL b2b_in_ready_in_send got %0d want 0", inrdy_bad); end
        checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("[TB] FAIL b2b_frame_cnt got %h want %h", frame_cnt, exp_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        run_frame(8'h5A, 32'hDEADBEEF, 32'd0, 32'd50, 0, 3);
        rst_n = 1'b0;
        #1;
        checks++; if (got_q.size() != 3) begin errors++; $display("[TB] FAIL rstmid_progress got %0d want 3", got_q.size()); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_tx_valid got %b want 0", tx_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_in_ready got %b want 1", in_ready); end
        checks++; if (busy !== 1'b0 || tx_byte !== 8'h00) begin errors++; $display("[TB] FAIL rstmid_outputs got busy %b byte %h want 0 00", busy, tx_byte); end
        checks++; if (frame_cnt !== 16'h0) begin errors++; $display("[TB] FAIL rstmid_frame_cnt got %h want 0000", frame_cnt); end
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 16'h0;
        build_exp(8'h5A, 32'hDEADBEEF, 32'd0, 32'd50);
        run_frame(8'h5A, 32'hDEADBEEF, 32'd0, 32'd50, 0, 0);
        exp_cnt++;
        checks++; if (got_q.size() != N || got_q[0] !== 8'hA5) begin errors++; $display("[TB] FAIL rstmid_restart got len %0d want %0d starting A5", got_q.size(), N); end
        for (int i = 1; i < N && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL rstmid_byte%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("[TB] FAIL rstmid_frame_cnt_after got %h want %h", frame_cnt, exp_cnt); end
    endtask

    task automatic test_cnt_wrap();
        @(negedge clk);
        force dut.frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt;
        #1;
        checks++; if (frame_cnt !== 16'hFFFF) begin errors++; $display("[TB] FAIL wrap_preload got %h want ffff", frame_cnt); end
        build_exp(8'h99, 32'h00000001, 32'd7, 32'd7);
        run_frame(8'h99, 32'h00000001, 32'd7, 32'd7, 0, 0);
        checks++; if (timed_out || got_q.size() != N) begin errors++; $display("[TB] FAIL wrap_len got %0d want %0d", got_q.size(), N); end
        checks++; if (frame_cnt !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_frame_cnt got %h want 0000", frame_cnt); end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_type       = 8'h00;
        in_data       = 32'h0;
        in_t_ingress  = 32'h0;
        in_t_decision = 32'h0;
        tx_ready      = 1'b0;
        exp_cnt       = 16'h0;
        test_reset();
        test_basic();
        test_stall();
        test_latency();
        test_random();
        test_back_to_back();
        test_reset_mid_frame();
        test_cnt_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
